demux_stream: RTL and testbench
===============================

Name: demux_stream

Overview:
- Registered, parametrised 1-to-NUM_CH demultiplexer for WIDTH-bit data, with valid/ready handshake on the input and on every output channel.
- Adds to the plain combinational demux:
  - one-entry holding register per channel;
  - backpressure;
  - broadcast mode and a per-channel enable mask;
  - error flag and saturating counter for discarded beats.
- Sits between a single producer and NUM_CH independent consumers.

Parameters:
- WIDTH, 8, data bits per beat.
- NUM_CH, 16, number of output channels (2..64; need not be a power of two).
- SEL_W, $clog2(NUM_CH), select width (localparam, derived).
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  input payload.
- in_sel  in  SEL_W  target channel (ignored when in_bcast=1).
- in_bcast  in  1  broadcast beat to all enabled channels.
- chan_en  in  NUM_CH  per-channel enable mask (quasi-static).
- out_valid  out  NUM_CH  per-channel valid.
- out_ready  in  NUM_CH  per-channel ready.
- out_data  out  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- err_drop  out  1  one-cycle pulse, registered, when a beat is discarded.
- drop_cnt  out  CNT_W  saturating count of discarded beats.
- cnt_clr  in  1  synchronous clear of drop_cnt.

Behaviour:
- Reset (async, rst_n=0):
  - all out_valid=0, out_data=0, err_drop=0, drop_cnt=0.
  - in_ready is combinational and evaluates per the rules below, so it is 1 for legal beats.
  - Reset mid-operation loses all held beats, with no drop count.
- Per channel k:
  - Holding register (valid_q[k], data_q[k]); out_valid[k]=valid_q[k].
  - slot_free[k] = !valid_q[k] || out_ready[k].
- Unicast (in_bcast=0, in_sel<NUM_CH, chan_en[in_sel]=1):
  - in_ready = slot_free[in_sel].
  - On accept, data_q[in_sel] <= in_data and valid_q[in_sel] <= 1 at the next edge.
  - Latency: 1 cycle from accept to out_valid.
- Broadcast (in_bcast=1, chan_en!=0):
  - in_ready = AND over enabled k of slot_free[k].
  - On accept, all enabled channels load in_data in the same edge.
  - Disabled channels are untouched.
- Discard cases:
  - unicast with in_sel>=NUM_CH;
  - unicast with chan_en[in_sel]=0;
  - broadcast with chan_en==0.
  - In each case in_ready=1 (never stalls), the beat is consumed, err_drop=1 on the next cycle, and drop_cnt increments.
- Drain: valid_q[k] clears when out_valid[k] && out_ready[k] and no load to k in the same cycle.
- Simultaneous drain and load on the same channel: valid_q stays 1 and data_q takes the new beat. This gives full throughput of 1 beat/cycle per channel.
- in_ready depends combinationally on out_ready, chan_en, in_sel and in_bcast. There is no combinational path from in_valid to in_ready.
- out_data[k] holds stable while out_valid[k]=1 && out_ready[k]=0. in_valid is not required for stability.
- drop_cnt:
  - saturates at all-ones (no wrap);
  - cnt_clr has priority over an increment in the same cycle, so the result is 0.
- chan_en deasserted while a channel holds a beat: the held beat still drains normally; only new loads are affected.
- Upstream must hold in_data, in_sel and in_bcast while in_valid && !in_ready. This is not checked.

Decomposition:
- Shared package demux_pkg:
  - default WIDTH/NUM_CH/CNT_W constants;
  - a function computing SEL_W;
  - mode encoding constants MODE_UNICAST=0, MODE_BCAST=1.
- One natural sub-module, demux_slot:
  - the single-channel holding register with load/drain logic;
  - ports clk, rst_n, load, load_data, out_ready, out_valid, out_data, slot_free.
- Top level instantiates demux_slot NUM_CH times via generate, plus select decode, ready mux and drop counter.

Test Plan:
- Reset then unicast in_sel=3, in_data=8'hA5, out_ready=all 1 -> out_valid[3]=1 with data A5 exactly 1 cycle later; all other out_valid=0.
- Backpressure: out_ready[5]=0, send 8'h11 then 8'h22 to ch5 -> in_ready drops after first accept; ch5 holds 11; raising out_ready[5] drains 11 and accepts 22 in the same cycle.
- Throughput: continuous unicast to ch0 with out_ready[0]=1, 16 beats 0x00..0x0F -> in_ready never low; outputs 0x00..0x0F on consecutive cycles.
- Broadcast: chan_en=16'h00FF, in_bcast=1, in_data=8'h3C, out_ready[2]=0 with ch2 occupied -> in_ready=0; after ch2 drains, channels 0..7 all show 3C; channels 8..15 show no valid.
- Discard: NUM_CH=10, in_sel=12 -> in_ready=1, err_drop pulses once, drop_cnt=1; same test with chan_en[4]=0 and in_sel=4 -> drop_cnt=2; cnt_clr with a concurrent drop -> drop_cnt=0.
- Saturation and reset: CNT_W=4, 20 discards -> drop_cnt=15; assert rst_n=0 mid-stream with ch7 holding a beat -> out_valid=0 and drop_cnt=0 immediately (asynchronous).

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
// Imported by demux_slot and demux_stream.
package demux_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int NUM_CH_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  localparam logic MODE_UNICAST = 1'b0;
  localparam logic MODE_BCAST   = 1'b1;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// A load in the same cycle as a drain keeps the slot full.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             slot_free
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign slot_free = !valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-NUM_CH stream demux with broadcast,
// channel enable mask and saturating drop counter.
module demux_stream
  import demux_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int SEL_W  = sel_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  input  logic [NUM_CH-1:0]       chan_en,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    err_drop,
  output logic [CNT_W-1:0]        drop_cnt,
  input  logic                    cnt_clr
);

  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] sel_hot;
  logic [NUM_CH-1:0] tgt;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] slot_free;
  logic              sel_ok;
  logic              bcast;
  logic              discard;
  logic              accept;
  logic              drop;

  assign sel_ok = {1'b0, in_sel} < NCH;
  assign bcast  = (in_bcast == MODE_BCAST);

  // An empty target set means the beat has nowhere to go.
  assign tgt      = bcast ? chan_en : (sel_hot & chan_en);
  assign discard  = ~|tgt;
  assign in_ready = discard | (&(slot_free | ~tgt));
  assign accept   = in_valid & in_ready;
  assign load     = accept ? tgt : '0;
  assign drop     = accept & discard;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign sel_hot[k] = sel_ok && (in_sel == SEL_W'(k));

    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .load_data(in_data),
      .out_ready(out_ready[k]),
      .out_valid(out_valid[k]),
      .out_data (out_data[k*WIDTH +: WIDTH]),
      .slot_free(slot_free[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_drop <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_drop <= drop;
      if (cnt_clr) begin
        drop_cnt <= '0;
      end else if (drop && !(&drop_cnt)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream (10 channels, 4-bit counter)
// with a per-cycle reference model and literal spot checks.
module tb_demux_stream;

  localparam int W  = 8;
  localparam int N  = 10;
  localparam int CW = 4;
  localparam int SW = 4;

  logic            clk = 0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [SW-1:0]   in_sel;
  logic            in_bcast;
  logic [N-1:0]    chan_en;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*W-1:0]  out_data;
  logic            err_drop;
  logic [CW-1:0]   drop_cnt;
  logic            cnt_clr;

  int total = 0;
  int bad   = 0;

  bit       m_v [N];
  bit [7:0] m_d [N];
  bit       m_err;
  int       m_cnt;

  demux_stream #(
    .WIDTH (W),
    .NUM_CH(N),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_bcast (in_bcast),
    .chan_en  (chan_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err_drop (err_drop),
    .drop_cnt (drop_cnt),
    .cnt_clr  (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hit(int k);
    if (in_bcast) return chan_en[k];
    return (int'(in_sel) == k) && chan_en[k];
  endfunction

  function automatic bit dropping();
    for (int k = 0; k < N; k++)
      if (hit(k)) return 1'b0;
    return 1'b1;
  endfunction

  // Ready: never stall a beat that will be discarded; otherwise every
  // targeted channel must be empty or draining this cycle.
  function automatic bit m_ready();
    if (dropping()) return 1'b1;
    for (int k = 0; k < N; k++)
      if (hit(k) && m_v[k] && !out_ready[k]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_v[k] <= 1'b0;
        m_d[k] <= 8'h00;
      end
      m_err <= 1'b0;
      m_cnt <= 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (in_valid && m_ready() && hit(k)) begin
          m_v[k] <= 1'b1;
          m_d[k] <= in_data;
        end else if (out_ready[k]) begin
          m_v[k] <= 1'b0;
        end
      end
      m_err <= in_valid && dropping();
      if (cnt_clr) m_cnt <= 0;
      else if (in_valid && dropping() && m_cnt < 15) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 16'(in_ready), 16'(m_ready()));
    for (int k = 0; k < N; k++) begin
      chk($sformatf("valid%0d", k), 16'(out_valid[k]), 16'(m_v[k]));
      chk($sformatf("data%0d", k), 16'(out_data[k*W +: W]), 16'(m_d[k]));
    end
    chk("err_drop", 16'(err_drop), 16'(m_err));
    chk("drop_cnt", 16'(drop_cnt), 16'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0;
    chan_en = '1; out_ready = '1; cnt_clr = 0;
    #1;
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_cnt", 16'(drop_cnt), 16'h0);
    chk("rst_err", 16'(err_drop), 16'h0);
    chk("rst_ready", 16'(in_ready), 16'h1);
    step(); step();
    rst_n = 1;
    step();

    // unicast, one-cycle latency
    in_valid = 1; in_sel = 3; in_data = 8'hA5;
    step();
    in_valid = 0;
    chk("uni_valid", 16'(out_valid), 16'h008);
    chk("uni_data", 16'(out_data[3*W +: W]), 16'hA5);
    step();
    chk("uni_drain", 16'(out_valid), 16'h000);

    // backpressure on ch5
    out_ready[5] = 0;
    in_valid = 1; in_sel = 5; in_data = 8'h11;
    #1 chk("bp_rdy0", 16'(in_ready), 16'h1);
    step();
    in_data = 8'h22;
    #1 chk("bp_rdy1", 16'(in_ready), 16'h0);
    step();
    chk("bp_hold", 16'(out_data[5*W +: W]), 16'h11);
    chk("bp_rdy2", 16'(in_ready), 16'h0);
    out_ready[5] = 1;
    #1 chk("bp_rdy3", 16'(in_ready), 16'h1);
    step();
    in_valid = 0;
    chk("bp_new", 16'(out_data[5*W +: W]), 16'h22);
    chk("bp_v", 16'(out_valid), 16'h020);
    step();

    // full throughput on ch0
    in_sel = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = 8'(i);
      #1 chk("tp_rdy", 16'(in_ready), 16'h1);
      step();
      chk("tp_data", 16'(out_data[W-1:0]), 16'(i));
    end
    in_valid = 0;
    step();

    // broadcast blocked by busy ch2
    chan_en = 10'h0FF;
    out_ready[2] = 0;
    in_valid = 1; in_sel = 2; in_data = 8'h77;
    step();
    in_bcast = 1; in_data = 8'h3C;
    #1 chk("bc_rdy0", 16'(in_ready), 16'h0);
    step();
    chk("bc_hold", 16'(out_valid), 16'h004);
    out_ready[2] = 1;
    #1 chk("bc_rdy1", 16'(in_ready), 16'h1);
    step();
    in_valid = 0; in_bcast = 0;
    chk("bc_valid", 16'(out_valid), 16'h0FF);
    for (int k = 0; k < 8; k++)
      chk("bc_data", 16'(out_data[k*W +: W]), 16'h3C);
    step();

    // discards
    chan_en = '1;
    in_valid = 1; in_sel = 12; in_data = 8'hEE;
    #1 chk("dc_rdy", 16'(in_ready), 16'h1);
    step();
    in_valid = 0;
    chk("dc_err", 16'(err_drop), 16'h1);
    chk("dc_cnt1", 16'(drop_cnt), 16'h1);
    step();
    chk("dc_pulse", 16'(err_drop), 16'h0);
    chan_en[4] = 0;
    in_valid = 1; in_sel = 4;
    #1 chk("dc_rdy4", 16'(in_ready), 16'h1);
    step();
    in_valid = 0;
    chk("dc_cnt2", 16'(drop_cnt), 16'h2);
    chk("dc_nold", 16'(out_valid), 16'h000);
    in_valid = 1; in_sel = 12; cnt_clr = 1;
    step();
    in_valid = 0; cnt_clr = 0;
    chk("dc_clr", 16'(drop_cnt), 16'h0);
    chk("dc_clr_err", 16'(err_drop), 16'h1);
    chan_en = '0; in_bcast = 1; in_valid = 1;
    step();
    in_valid = 0; in_bcast = 0; chan_en = '1;
    chk("dc_bc0", 16'(drop_cnt), 16'h1);

    // saturation
    in_valid = 1; in_sel = 12;
    for (int i = 0; i < 20; i++) step();
    in_valid = 0;
    chk("sat", 16'(drop_cnt), 16'hF);
    step();

    // async reset with ch7 holding a beat
    out_ready[7] = 0;
    in_valid = 1; in_sel = 7; in_data = 8'h5A;
    step();
    in_valid = 0;
    chk("r_hold", 16'(out_valid), 16'h080);
    #2 rst_n = 0;
    #1;
    chk("r_valid", 16'(out_valid), 16'h000);
    chk("r_cnt", 16'(drop_cnt), 16'h0);
    chk("r_data", 16'(out_data[7*W +: W]), 16'h00);
    step();
    rst_n = 1; out_ready = '1;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
